// File: rtl/graph_path_trace.sv
// rtl/graph_path_trace.sv - backward path tracer over level/adjacency RAMs; optional GRAPH_TRACE_MASK_EN adds path_mask
module graph_path_trace #(
    parameter int NODE_W  = 7,
    parameter int EDGE_W  = 11,
    parameter int LEVEL_W = 4,
    parameter int DEG_W   = 3
`ifdef GRAPH_TRACE_MASK_EN
    ,
    parameter int EDGE_NUM = 1034
`endif
) (
`ifdef GRAPH_TRACE_MASK_EN
    output logic [EDGE_NUM-1:0]            path_mask,
`endif
    input  logic                           CLK,
    input  logic                           RST_n,
    input  logic                           start,
    input  logic [NODE_W-1:0]              start_node,
    input  logic [NODE_W-1:0]              end_node,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [NODE_W-1:0]              lvl_addr,
    input  logic [LEVEL_W-1:0]             lvl_rdata,
    output logic [NODE_W+DEG_W-1:0]        adj_addr,
    input  logic [NODE_W+EDGE_W:0]         adj_rdata,
    output logic                           edge_valid,
    input  logic                           edge_ready,
    output logic [EDGE_W-1:0]              edge_id,
    output logic                           edge_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_END, S_SCAN, S_RD_NLVL, S_CHECK, S_EMIT, S_DONE, S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic [NODE_W-1:0]       start_q, cur, nbr;
    logic [LEVEL_W-1:0]      curlvl;
    logic [DEG_W-1:0]        slot;
    logic [EDGE_W-1:0]       edge_q;
    logic [NODE_W-1:0]       lvl_addr_q;
    logic [NODE_W+DEG_W-1:0] adj_addr_q;

    logic                    a_valid;
    logic [NODE_W-1:0]       a_nbr;
    logic [EDGE_W-1:0]       a_edge;
    logic [LEVEL_W-1:0]      lvl_m1;
    logic [DEG_W-1:0]        slot_inc;
    logic                    match;

    assign a_valid  = adj_rdata[NODE_W+EDGE_W];
    assign a_nbr    = adj_rdata[NODE_W+EDGE_W-1:EDGE_W];
    assign a_edge   = adj_rdata[EDGE_W-1:0];
    assign lvl_m1   = curlvl - LEVEL_W'(1);
    assign slot_inc = slot + DEG_W'(1);
    assign match    = (lvl_rdata == lvl_m1) && (lvl_rdata != '1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_RD_END;
            S_RD_END: begin
                if (lvl_rdata == '1)                            state_nxt = S_FAIL;
                else if (cur == start_q || lvl_rdata == '0)     state_nxt = S_DONE;
                else                                            state_nxt = S_SCAN;
            end
            S_SCAN:    state_nxt = a_valid ? S_RD_NLVL : S_FAIL;
            S_RD_NLVL: state_nxt = S_CHECK;
            S_CHECK: begin
                if (match)             state_nxt = S_EMIT;
                else if (slot == '1)   state_nxt = S_FAIL;
                else                   state_nxt = S_SCAN;
            end
            S_EMIT:    if (edge_ready) state_nxt = edge_last ? S_DONE : S_SCAN;
            S_DONE:    state_nxt = S_IDLE;
            S_FAIL:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Addresses are presented combinationally in the deciding cycle so the
    // synchronous RAMs return data in the state that consumes it.
    always_comb begin
        busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_FAIL);
        done       = (state == S_DONE);
        fail       = (state == S_FAIL);
        edge_valid = (state == S_EMIT);
        lvl_addr   = lvl_addr_q;
        adj_addr   = adj_addr_q;
        case (state)
            S_IDLE:   if (start) lvl_addr = end_node;
            S_RD_END: if (lvl_rdata != '1 && lvl_rdata != '0 && cur != start_q)
                          adj_addr = {cur, {DEG_W{1'b0}}};
            S_SCAN:   if (a_valid) lvl_addr = a_nbr;
            S_CHECK:  if (!match && slot != '1) adj_addr = {cur, slot_inc};
            S_EMIT:   if (edge_ready && !edge_last) adj_addr = {nbr, {DEG_W{1'b0}}};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            start_q    <= '0;
            cur        <= '0;
            nbr        <= '0;
            curlvl     <= '0;
            slot       <= '0;
            edge_q     <= '0;
            edge_id    <= '0;
            edge_last  <= 1'b0;
            lvl_addr_q <= '0;
            adj_addr_q <= '0;
        end else begin
            lvl_addr_q <= lvl_addr;
            adj_addr_q <= adj_addr;
            case (state)
                S_IDLE: if (start) begin
                    start_q <= start_node;
                    cur     <= end_node;
                end
                S_RD_END: begin
                    curlvl <= lvl_rdata;
                    slot   <= '0;
                end
                S_SCAN: if (a_valid) begin
                    nbr    <= a_nbr;
                    edge_q <= a_edge;
                end
                S_CHECK: begin
                    if (match) begin
                        edge_id   <= edge_q;
                        edge_last <= (lvl_m1 == '0);
                    end else if (slot != '1) begin
                        slot <= slot_inc;
                    end
                end
                S_EMIT: if (edge_ready && !edge_last) begin
                    cur    <= nbr;
                    curlvl <= lvl_m1;
                    slot   <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef GRAPH_TRACE_MASK_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            path_mask <= '0;
        else if (state == S_IDLE && start)
            path_mask <= '0;
        else if (state == S_EMIT && edge_ready)
            path_mask <= path_mask | ({{(EDGE_NUM-1){1'b0}}, 1'b1} << edge_id);
    end
`endif

endmodule
